// File: rtl/id_regs_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module  : id_regs_reader_pkg
// Purpose : Shared widths, the ID/EX payload layout and a small operand-select
//           helper for the ID-stage operand reader and its consumers.
// Ports   : (package - no ports)
// Rev     : 1.0  initial release
// ============================================================================
package id_regs_reader_pkg;

  localparam int DATA_W  = 32;              // GPR data width
  localparam int ADDR_W  = 5;               // GPR index width
  localparam int CNT_W   = 3;               // in-flight write counter width
  localparam int NREGS   = 1 << ADDR_W;     // register count, r0 included
  localparam int CNT_MAX = (1 << CNT_W) - 1; // saturation value of a counter

  // Payload carried by the ID/EX pipeline register (valid travels separately).
  typedef struct packed {
    logic              rd_we;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rj_data;
    logic [DATA_W-1:0] rk_data;
  } idex_bus_t;

  // Width of the ID/EX bus as seen by the EX stage.
  localparam int IDEX_BUS_W = $bits(idex_bus_t);

  // Operand select: unused/r0 sources read as zero, a same-cycle write-back
  // wins over the (stale) register-file read data.
  function automatic logic [DATA_W-1:0] pick_operand(
    input logic              used,
    input logic              bypass,
    input logic [DATA_W-1:0] wb_data,
    input logic [DATA_W-1:0] rf_data
  );
    if (!used)       return '0;
    else if (bypass) return wb_data;
    else             return rf_data;
  endfunction

endpackage
`default_nettype wire

// File: rtl/id_regs_reader_scoreboard.sv
`default_nettype none
// ============================================================================
// Module  : reg_scoreboard
// Purpose : Per-register in-flight write counters (r1..r31). Counts issued
//           writers minus retired write-backs; flags a retire to an idle reg.
// Ports   : clk, rst_n           - clock, async active-low reset
//           i_inc, i_inc_addr    - issue of a writer to i_inc_addr
//           i_dec_req, i_dec_addr- write-back request to i_dec_addr
//           i_flush              - clear every counter next cycle
//           i_q{a,b}_addr        - lookup ports -> o_q{a,b}_zero / _one
//           i_sat_addr, o_sat    - counter at i_sat_addr is saturated
//           o_err                - sticky: write-back hit a zero counter
// Rev     : 1.0  initial release
// ============================================================================
module reg_scoreboard
  import id_regs_reader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_inc,
  input  logic [ADDR_W-1:0] i_inc_addr,
  input  logic              i_dec_req,
  input  logic [ADDR_W-1:0] i_dec_addr,
  input  logic              i_flush,
  input  logic [ADDR_W-1:0] i_qa_addr,
  output logic              o_qa_zero,
  output logic              o_qa_one,
  input  logic [ADDR_W-1:0] i_qb_addr,
  output logic              o_qb_zero,
  output logic              o_qb_one,
  input  logic [ADDR_W-1:0] i_sat_addr,
  output logic              o_sat,
  output logic              o_err
);

  // Flat view of all counters; entry 0 is a constant so lookups need no guard.
  logic [CNT_W-1:0] w_cnt [NREGS];
  logic             w_err_hit;
  logic             r_err;

  assign w_cnt[0] = '0;

  generate
    for (genvar gi = 1; gi < NREGS; gi++) begin : g_cnt
      logic [CNT_W-1:0] r_cnt;
      logic             w_inc;
      logic             w_dec;

      assign w_inc = i_inc && (i_inc_addr == ADDR_W'(gi));
      // A retire to an idle counter is an error, not an underflow.
      assign w_dec = i_dec_req && (i_dec_addr == ADDR_W'(gi)) && (r_cnt != '0);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               r_cnt <= '0;
        else if (i_flush)         r_cnt <= '0;
        else if (w_inc && !w_dec) r_cnt <= r_cnt + 1'b1;
        else if (w_dec && !w_inc) r_cnt <= r_cnt - 1'b1;
      end

      assign w_cnt[gi] = r_cnt;
    end
  endgenerate

  assign o_qa_zero = (w_cnt[i_qa_addr] == '0);
  assign o_qa_one  = (w_cnt[i_qa_addr] == CNT_W'(1));
  assign o_qb_zero = (w_cnt[i_qb_addr] == '0);
  assign o_qb_one  = (w_cnt[i_qb_addr] == CNT_W'(1));
  assign o_sat     = (w_cnt[i_sat_addr] == CNT_W'(CNT_MAX));

  // r0 is never tracked, so a write-back to r0 is not counted as an error.
  assign w_err_hit = i_dec_req && (i_dec_addr != '0) && (w_cnt[i_dec_addr] == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_err <= 1'b0;
    else if (w_err_hit) r_err <= 1'b1;
  end

  assign o_err = r_err;

endmodule
`default_nettype wire

// File: rtl/id_regs_reader.sv
`default_nettype none
// ============================================================================
// Module  : id_regs_reader
// Purpose : ID-stage operand reader. Drives GPR read addresses, checks the
//           in-flight write scoreboard, bypasses a same-cycle write-back and
//           issues into the ID/EX register or stalls.
// Ports   : clk, rst_n                     - clock, async active-low reset
//           id_valid_i, r{j,k}_re_i/addr_i - decoded instruction, sources
//           rd_we_i, rd_addr_i             - destination
//           ex_allowin_i, flush_i          - EX handshake, pipeline flush
//           r{j,k}_raddr_o / r{j,k}_rdata_i- register-file read port
//           wb_we_i, wb_waddr_i, wb_wdata_i- WB register-write bus
//           id_allowin_o                   - ID may load a new instruction
//           ex_valid_o, ex_*_o             - ID/EX register outputs
//           sb_err_o                       - sticky scoreboard error
// Rev     : 1.0  initial release
// ============================================================================
module id_regs_reader
  import id_regs_reader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid_i,
  input  logic              rj_re_i,
  input  logic              rk_re_i,
  input  logic [ADDR_W-1:0] rj_addr_i,
  input  logic [ADDR_W-1:0] rk_addr_i,
  input  logic              rd_we_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic              ex_allowin_i,
  input  logic              flush_i,
  output logic [ADDR_W-1:0] rj_raddr_o,
  output logic [ADDR_W-1:0] rk_raddr_o,
  input  logic [DATA_W-1:0] rj_rdata_i,
  input  logic [DATA_W-1:0] rk_rdata_i,
  input  logic              wb_we_i,
  input  logic [ADDR_W-1:0] wb_waddr_i,
  input  logic [DATA_W-1:0] wb_wdata_i,
  output logic              id_allowin_o,
  output logic              ex_valid_o,
  output logic [DATA_W-1:0] ex_rj_data_o,
  output logic [DATA_W-1:0] ex_rk_data_o,
  output logic              ex_rd_we_o,
  output logic [ADDR_W-1:0] ex_rd_addr_o,
  output logic              sb_err_o
);

  logic      w_rj_used, w_rk_used;
  logic      w_rj_zero, w_rj_one, w_rk_zero, w_rk_one;
  logic      w_rj_byp, w_rk_byp;
  logic      w_rj_haz, w_rk_haz;
  logic      w_rd_live, w_rd_sat, w_ovf;
  logic      w_issue;
  idex_bus_t w_ex_bus;
  logic      r_ex_valid;
  idex_bus_t r_ex_bus;

  assign rj_raddr_o = rj_addr_i;
  assign rk_raddr_o = rk_addr_i;

  reg_scoreboard u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_inc      (w_issue && w_rd_live),
    .i_inc_addr (rd_addr_i),
    .i_dec_req  (wb_we_i),
    .i_dec_addr (wb_waddr_i),
    .i_flush    (flush_i),
    .i_qa_addr  (rj_addr_i),
    .o_qa_zero  (w_rj_zero),
    .o_qa_one   (w_rj_one),
    .i_qb_addr  (rk_addr_i),
    .o_qb_zero  (w_rk_zero),
    .o_qb_one   (w_rk_one),
    .i_sat_addr (rd_addr_i),
    .o_sat      (w_rd_sat),
    .o_err      (sb_err_o)
  );

  assign w_rj_used = rj_re_i && (rj_addr_i != '0);
  assign w_rk_used = rk_re_i && (rk_addr_i != '0);

  // Bypass only when the retiring write is the last one outstanding;
  // with more writers in flight the WB data is already stale for us.
  assign w_rj_byp = w_rj_used && w_rj_one && wb_we_i && (wb_waddr_i == rj_addr_i);
  assign w_rk_byp = w_rk_used && w_rk_one && wb_we_i && (wb_waddr_i == rk_addr_i);

  assign w_rj_haz = w_rj_used && !w_rj_zero && !w_rj_byp;
  assign w_rk_haz = w_rk_used && !w_rk_zero && !w_rk_byp;

  assign w_rd_live = rd_we_i && (rd_addr_i != '0);
  assign w_ovf     = w_rd_live && w_rd_sat;

  assign w_issue = id_valid_i && ex_allowin_i && !flush_i
                 && !w_rj_haz && !w_rk_haz && !w_ovf;

  assign id_allowin_o = !id_valid_i || w_issue;

  always_comb begin
    w_ex_bus         = '0;
    w_ex_bus.rd_we   = rd_we_i;
    w_ex_bus.rd_addr = rd_addr_i;
    w_ex_bus.rj_data = pick_operand(w_rj_used, w_rj_byp, wb_wdata_i, rj_rdata_i);
    w_ex_bus.rk_data = pick_operand(w_rk_used, w_rk_byp, wb_wdata_i, rk_rdata_i);
  end

  // Payload only moves on issue; a drain (flush or EX taking the old entry)
  // just drops valid and leaves the data fields as they were.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid <= 1'b0;
      r_ex_bus   <= '0;
    end else if (w_issue) begin
      r_ex_valid <= 1'b1;
      r_ex_bus   <= w_ex_bus;
    end else if (flush_i || ex_allowin_i) begin
      r_ex_valid <= 1'b0;
    end
  end

  assign ex_valid_o   = r_ex_valid;
  assign ex_rj_data_o = r_ex_bus.rj_data;
  assign ex_rk_data_o = r_ex_bus.rk_data;
  assign ex_rd_we_o   = r_ex_bus.rd_we;
  assign ex_rd_addr_o = r_ex_bus.rd_addr;

endmodule
`default_nettype wire
